mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative 32-bit multiply/divide unit with architectural
// HI/LO registers.
//
// MULT/MULTU run as 32 shift-add steps on operand magnitudes; DIV/DIVU run as
// 32 restoring shift-subtract steps. Each op then spends one FIN cycle, where
// sign correction happens. HI/LO are written at the edge that leaves FIN.
// MTHI/MTLO write HI/LO directly at the accepting edge. Ops 110/111 are no-ops.
//
// Build option: define MDU_DIV_EN to include the divider. Without it, ops
// 010/011 behave as no-ops.
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request, taken when busy=0 and cancel=0
//   op      in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A       in  32   multiplicand / dividend / MTHI-MTLO source
//   B       in  32   multiplier / divisor
//   cancel  in   1   abort an in-flight operation (pipeline flush)
//   busy    out  1   iterative operation in progress
//   done    out  1   one-cycle pulse after an iterative op writes HI/LO
//   HI      out 32   product high word / remainder
//   LO      out 32   product low word / quotient
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [32:0] acc_hi;     // running partial product / partial remainder
    logic [31:0] acc_lo;     // multiplier bits / dividend bits shifting into quotient
    logic [31:0] opnd;       // multiplicand or divisor magnitude
    logic        neg_lo;     // negate 64-bit product, or quotient

    logic        accept;
    logic        iter_op;
    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] acc_hi_nxt;
    logic [31:0] acc_lo_nxt;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

`ifdef MDU_DIV_EN
    logic        is_div;
    logic        neg_hi;     // remainder takes the sign of the dividend
    logic [32:0] rem_sh;
`endif

    assign busy   = (state != IDLE);
    assign accept = start && !busy && !cancel;

    // Operation decode and operand magnitudes
    always_comb begin
        iter_op   = (op == OP_MULT) || (op == OP_MULTU);
        signed_op = (op == OP_MULT);
`ifdef MDU_DIV_EN
        iter_op   = iter_op || (op == OP_DIV) || (op == OP_DIVU);
        signed_op = signed_op || (op == OP_DIV);
`endif
        a_mag = (signed_op && A[31]) ? (32'd0 - A) : A;
        b_mag = (signed_op && B[31]) ? (32'd0 - B) : B;
    end

    // One iteration step
    always_comb begin
        // Add multiplicand when the current multiplier bit is set, then shift the
        // 65-bit {acc_hi, acc_lo} pair right by one. The product collects in place.
        mul_sum    = acc_lo[0] ? (acc_hi + {1'b0, opnd}) : acc_hi;
        acc_hi_nxt = {1'b0, mul_sum[32:1]};
        acc_lo_nxt = {mul_sum[0], acc_lo[31:1]};
`ifdef MDU_DIV_EN
        rem_sh = {acc_hi[31:0], acc_lo[31]};
        if (is_div) begin
            // Restoring step: subtract only when the shifted remainder covers
            // the divisor. A zero divisor always subtracts, which yields an
            // all-ones quotient and the dividend as remainder.
            if (rem_sh >= {1'b0, opnd}) begin
                acc_hi_nxt = rem_sh - {1'b0, opnd};
                acc_lo_nxt = {acc_lo[30:0], 1'b1};
            end else begin
                acc_hi_nxt = rem_sh;
                acc_lo_nxt = {acc_lo[30:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction of the finished magnitudes
    always_comb begin
        prod     = {acc_hi[31:0], acc_lo};
        prod_fix = neg_lo ? (64'd0 - prod) : prod;
        hi_res   = prod_fix[63:32];
        lo_res   = prod_fix[31:0];
`ifdef MDU_DIV_EN
        if (is_div) begin
            lo_res = neg_lo ? (32'd0 - acc_lo) : acc_lo;
            hi_res = neg_hi ? (32'd0 - acc_hi[31:0]) : acc_hi[31:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end else if (iter_op) begin
                            state  <= CALC;
                            cnt    <= '0;
                            acc_hi <= '0;
                            neg_lo <= signed_op && (A[31] ^ B[31]);
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
`ifdef MDU_DIV_EN
                            is_div <= op[1];
                            neg_hi <= (op == OP_DIV) && A[31];
                            if (op[1]) begin
                                acc_lo <= a_mag;
                                opnd   <= b_mag;
                            end
`endif
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= acc_hi_nxt;
                        acc_lo <= acc_lo_nxt;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!cancel) begin
                        HI   <= hi_res;
                        LO   <= lo_res;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- self-checking bench for mul_div_unit.
// A behavioural model tracks the expected HI/LO/busy/done from the operation
// semantics, and a compare process checks the DUT against it on every falling
// edge. Directed cases pin the model with literal values. A randomized phase
// follows the directed cases. Define MDU_DIV_EN for both bench and RTL to
// cover the divider.
`timescale 1ns/1ps
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail = 0;
    int lat;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q;
        int r;
        case (o)
            3'b000: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            3'b001: return {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b == 32'd0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit is_iter_m(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (DIV_EN && (o[2:1] == 2'b01));
    endfunction

    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    int          m_left;   // edges until the pending result lands; 0 = idle
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (cancel) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
                    end
                end
            end else if (start && !cancel) begin
                if (op == 3'b100) m_hi = A;
                else if (op == 3'b101) m_lo = A;
                else if (is_iter_m(op)) begin
                    {r_hi, r_lo} = ref_result(op, A, B);
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0;
        A = $urandom(); B = $urandom();
    endtask

    // Counts edges after acceptance until done is seen; bounded.
    task automatic wait_done(output int l);
        l = 0;
        do begin
            tick();
            l++;
        end while (done !== 1'b1 && l < 60);
    endtask

    logic [2:0] rop;

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MULT -2 * 3
        issue(3'b000, 32'hFFFFFFFE, 32'h00000003);
        check("mult_busy_rise", 32'(busy), 32'h1);
        wait_done(lat);
        check("mult_latency", lat, 33);
        check("mult_HI", HI, 32'hFFFFFFFF);
        check("mult_LO", LO, 32'hFFFFFFFA);
        tick();
        check("done_single", 32'(done), 32'h0);

        // MULTU max * max
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        check("multu_HI", HI, 32'hFFFFFFFE);
        check("multu_LO", LO, 32'h00000001);
        tick();

`ifdef MDU_DIV_EN
        issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
        wait_done(lat);
        check("div_latency", lat, 33);
        check("div_LO", LO, 32'hFFFFFFFD);
        check("div_HI", HI, 32'hFFFFFFFF);
        tick();
        issue(3'b011, 32'h00000007, 32'h0);
        wait_done(lat);
        check("divu0_LO", LO, 32'hFFFFFFFF);
        check("divu0_HI", HI, 32'h00000007);
        tick();
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        check("divovf_LO", LO, 32'h80000000);
        check("divovf_HI", HI, 32'h0);
        tick();
        issue(3'b010, 32'hFFFFFFF9, 32'h0);
        wait_done(lat);
        check("div0neg_LO", LO, 32'h00000001);
        check("div0neg_HI", HI, 32'hFFFFFFF9);
        tick();
`else
        issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
        check("nodiv_busy", 32'(busy), 32'h0);
        issue(3'b011, 32'h00000007, 32'h0);
        check("nodivu_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        check("nodiv_HI", HI, 32'hFFFFFFFE);
        check("nodiv_LO", LO, 32'h00000001);
`endif

        // Known HI/LO, then cancel at iteration 10 together with a start
        issue(3'b100, 32'hAAAA5555, 32'h0);
        issue(3'b101, 32'h11111111, 32'h0);
        check("mthi_HI", HI, 32'hAAAA5555);
        check("mtlo_LO", LO, 32'h11111111);
        issue(3'b000, 32'h00001234, 32'h00005678);
        repeat (9) tick();
        cancel = 1'b1; start = 1'b1; op = 3'b101; A = 32'hDEADBEEF;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("cancel_busy", 32'(busy), 32'h0);
        check("cancel_HI", HI, 32'hAAAA5555);
        check("cancel_LO", LO, 32'h11111111);
        // cancel with start while idle: start ignored
        cancel = 1'b1; start = 1'b1; op = 3'b100; A = 32'h0BADF00D;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("idle_cancel_HI", HI, 32'hAAAA5555);
        repeat (40) tick();
        check("cancel_noresult_LO", LO, 32'h11111111);

        // ops 110/111 are no-ops
        issue(3'b110, 32'h55555555, 32'h1);
        issue(3'b111, 32'h66666666, 32'h1);
        check("nop_busy", 32'(busy), 32'h0);
        check("nop_HI", HI, 32'hAAAA5555);

        // MTLO while busy ignored, MTLO after done accepted
        issue(3'b000, 32'h6, 32'h7);
        start = 1'b1; op = 3'b101; A = 32'h12345678;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("mul67_LO", LO, 32'd42);
        check("mul67_HI", HI, 32'd0);
        issue(3'b101, 32'h12345678, 32'h0);
        check("mtlo_after_LO", LO, 32'h12345678);
        check("mtlo_after_busy", 32'(busy), 32'h0);

        // cancel on the FIN edge suppresses the write and done
        issue(3'b000, 32'd100, 32'd200);
        repeat (32) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("finc_done", 32'(done), 32'h0);
        check("finc_LO", LO, 32'h12345678);
        tick();

        // asynchronous reset mid-operation
        rop = DIV_EN ? 3'b010 : 3'b000;
        issue(rop, 32'h00012345, 32'h00000077);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_HI", HI, 32'h0);
        check("arst_LO", LO, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; op = 3'b000; A = 32'd3; B = 32'd5;
        tick();
        start = 1'b0;
        check("post_rst_accept", 32'(busy), 32'h1);
        wait_done(lat);
        check("post_rst_LO", LO, 32'd15);
        check("post_rst_HI", HI, 32'd0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            op     = 3'($urandom_range(0, 7));
            A      = $urandom();
            B      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            if ($urandom_range(0, 15) == 0) begin
                A = 32'h80000000; B = 32'hFFFFFFFF;
            end
            cancel = ($urandom_range(0, 60) == 0);
            tick();
        end
        start = 1'b0; cancel = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
